// File: rtl/mem_sched_pkg.sv
// Shared constants and types for the 1024x8 dual-port memory scheduler:
// default widths, FSM state encoding and requester indices.
package mem_sched_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_1024x8_dp_sched_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational; the pointer names the
// requester that wins a tie and moves to the other requester after every grant.
module rr_arb2
    import mem_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       idx,
    output logic       any
);

    logic ptr;

    always_comb begin
        idx   = REQ0;
        any   = 1'b0;
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   begin idx = REQ0; any = 1'b1; end
                2'b10:   begin idx = REQ1; any = 1'b1; end
                2'b11:   begin idx = ptr;  any = 1'b1; end
                default: begin idx = REQ0; any = 1'b0; end
            endcase
            if (any) begin
                grant = (idx == REQ1) ? 2'b10 : 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= REQ0;
        end else if (any) begin
            ptr <= ~idx;
        end
    end

endmodule

// File: rtl/mem_1024x8_dp_sched.sv
// Scheduler in front of a 1024x8 dual-port memory: optional zero-fill after reset,
// then independent round-robin arbitration of two writers and two readers.
module mem_1024x8_dp_sched
    import mem_sched_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          rq_wvalid,
    output logic [1:0]          rq_wready,
    input  logic [2*ADDR_W-1:0] rq_waddr,
    input  logic [2*DATA_W-1:0] rq_wdata,
    input  logic [1:0]          rq_rvalid,
    output logic [1:0]          rq_rready,
    input  logic [2*ADDR_W-1:0] rq_raddr,
    output logic [1:0]          rq_rdvalid,
    output logic [DATA_W-1:0]   rq_rdata,
    output logic                init_done,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_data_in,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_raddr,
    output logic                mem_ren,
    output logic                mem_clk,
    input  logic [DATA_W-1:0]   mem_data_out,
    output state_t              fsm_state
);

    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic              run_en;
    logic              wr_idx, wr_any, rd_idx, rd_any;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        rd_pend;
    logic              byp_flag;
    logic [DATA_W-1:0] byp_data;

    assign mem_clk   = clk;
    assign fsm_state = state;

    // Reset is folded into the enables so nothing is granted or written while it is held.
    assign run_en = (state == ST_RUN) && !reset;

    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_cnt == CLR_LAST) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (state == ST_RUN || (state == ST_CLEAR && clr_cnt == CLR_LAST)) begin
                init_done <= 1'b1;
            end
        end
    end

    rr_arb2 u_warb (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .valid (rq_wvalid),
        .grant (rq_wready),
        .idx   (wr_idx),
        .any   (wr_any)
    );

    rr_arb2 u_rarb (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .valid (rq_rvalid),
        .grant (rq_rready),
        .idx   (rd_idx),
        .any   (rd_any)
    );

    assign wr_addr = (wr_idx == REQ1) ? rq_waddr[2*ADDR_W-1:ADDR_W] : rq_waddr[ADDR_W-1:0];
    assign wr_data = (wr_idx == REQ1) ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
    assign rd_addr = (rd_idx == REQ1) ? rq_raddr[2*ADDR_W-1:ADDR_W] : rq_raddr[ADDR_W-1:0];

    always_comb begin
        mem_wen     = 1'b0;
        mem_waddr   = '0;
        mem_data_in = '0;
        mem_ren     = 1'b0;
        mem_raddr   = '0;
        if (state == ST_CLEAR && !reset) begin
            mem_wen   = 1'b1;
            mem_waddr = clr_cnt;
        end else if (wr_any) begin
            mem_wen     = 1'b1;
            mem_waddr   = wr_addr;
            mem_data_in = wr_data;
        end
        if (rd_any) begin
            mem_ren   = 1'b1;
            mem_raddr = rd_addr;
        end
    end

    // The memory returns old data on a same-address collision, so the written
    // byte is captured here and substituted when the read data comes back.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 2'b00;
            byp_flag <= 1'b0;
            byp_data <= '0;
        end else begin
            rd_pend  <= rq_rready;
            byp_flag <= wr_any && rd_any && (wr_addr == rd_addr);
            byp_data <= wr_data;
        end
    end

    assign rq_rdvalid = reset ? 2'b00 : rd_pend;
    assign rq_rdata   = byp_flag ? byp_data : mem_data_out;

endmodule

// File: tb/tb_mem_1024x8_dp_sched.sv
// Directed bench for mem_1024x8_dp_sched with a behavioural 1024x8 dual-port
// memory (registered, read-old-data) attached to the memory-side ports.
module tb_mem_1024x8_dp_sched;
    import mem_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rq_wvalid, rq_wready, rq_rvalid, rq_rready, rq_rdvalid;
    logic [19:0] rq_waddr, rq_raddr;
    logic [15:0] rq_wdata;
    logic [7:0]  rq_rdata, mem_data_in, mem_data_out;
    logic        init_done, mem_wen, mem_ren, mem_clk;
    logic [9:0]  mem_waddr, mem_raddr;
    state_t      fsm_state;

    logic [7:0]  mem [1024];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_1024x8_dp_sched dut (
        .clk          (clk),
        .reset        (reset),
        .rq_wvalid    (rq_wvalid),
        .rq_wready    (rq_wready),
        .rq_waddr     (rq_waddr),
        .rq_wdata     (rq_wdata),
        .rq_rvalid    (rq_rvalid),
        .rq_rready    (rq_rready),
        .rq_raddr     (rq_raddr),
        .rq_rdvalid   (rq_rdvalid),
        .rq_rdata     (rq_rdata),
        .init_done    (init_done),
        .mem_waddr    (mem_waddr),
        .mem_data_in  (mem_data_in),
        .mem_wen      (mem_wen),
        .mem_raddr    (mem_raddr),
        .mem_ren      (mem_ren),
        .mem_clk      (mem_clk),
        .mem_data_out (mem_data_out),
        .fsm_state    (fsm_state)
    );

    always @(posedge mem_clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_data_in;
        if (mem_ren) mem_data_out <= mem[mem_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in the first clear cycle; returns at the negedge after n cycles.
    task automatic clear_run(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("clr_wen", {31'd0, mem_wen}, 32'd1);
            chk("clr_waddr", {22'd0, mem_waddr}, i);
            chk("clr_data", {24'd0, mem_data_in}, 32'd0);
            chk("clr_ren", {31'd0, mem_ren}, 32'd0);
            chk("clr_grants", {28'd0, rq_wready, rq_rready}, 32'd0);
            chk("clr_init_done", {31'd0, init_done}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
        mem_data_out = 8'h00;
        reset = 1'b1;
        rq_wvalid = 2'b00; rq_rvalid = 2'b00;
        rq_waddr = '0; rq_raddr = '0; rq_wdata = '0;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_ren", {31'd0, mem_ren}, 32'd0);
        chk("rst_rdvalid", {30'd0, rq_rdvalid}, 32'd0);
        chk("rst_state", {31'd0, fsm_state}, {31'd0, ST_CLEAR});

        // Full zero-fill with both requesters asking on both ports
        @(negedge clk);
        reset = 1'b0;
        rq_wvalid = 2'b11; rq_rvalid = 2'b11;
        clear_run(1024);
        rq_wvalid = 2'b00; rq_rvalid = 2'b00;
        #1;
        chk("init_done_rise", {31'd0, init_done}, 32'd1);
        chk("run_idle_wen", {31'd0, mem_wen}, 32'd0);
        chk("run_idle_waddr", {22'd0, mem_waddr}, 32'd0);
        chk("run_state", {31'd0, fsm_state}, {31'd0, ST_RUN});

        // Both writers held for four cycles: grants alternate 0,1,0,1
        @(negedge clk);
        rq_wvalid = 2'b11;
        rq_waddr = {10'h200, 10'h100};
        rq_wdata = {8'h22, 8'h11};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_wready", {30'd0, rq_wready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_wen", {31'd0, mem_wen}, 32'd1);
            chk("rr_waddr", {22'd0, mem_waddr}, (k % 2 == 0) ? 32'h100 : 32'h200);
            chk("rr_wdata", {24'd0, mem_data_in}, (k % 2 == 0) ? 32'h11 : 32'h22);
            @(negedge clk);
        end

        // Requester 0 writes 0xA5 to 0x3FF, then requester 1 reads it back
        rq_wvalid = 2'b01;
        rq_waddr = {10'h000, 10'h3FF};
        rq_wdata = {8'h00, 8'hA5};
        #1;
        chk("w3ff_wready", {30'd0, rq_wready}, 32'd1);
        chk("w3ff_waddr", {22'd0, mem_waddr}, 32'h3FF);
        @(negedge clk);
        rq_wvalid = 2'b00;
        rq_rvalid = 2'b10;
        rq_raddr = {10'h3FF, 10'h000};
        #1;
        chk("r3ff_rready", {30'd0, rq_rready}, 32'd2);
        chk("r3ff_ren", {31'd0, mem_ren}, 32'd1);
        chk("r3ff_raddr", {22'd0, mem_raddr}, 32'h3FF);
        chk("idle_wdata_zero", {24'd0, mem_data_in}, 32'd0);
        @(negedge clk);
        rq_rvalid = 2'b00;
        #1;
        chk("r3ff_rdvalid", {30'd0, rq_rdvalid}, 32'd2);
        chk("r3ff_rdata", {24'd0, rq_rdata}, 32'hA5);
        chk("idle_ren", {31'd0, mem_ren}, 32'd0);
        chk("idle_raddr_zero", {22'd0, mem_raddr}, 32'd0);

        // Same-cycle write 0x5A and read of 0x010 forwards the new byte
        @(negedge clk);
        chk("r3ff_single_pulse", {30'd0, rq_rdvalid}, 32'd0);
        rq_wvalid = 2'b01; rq_rvalid = 2'b01;
        rq_waddr = {10'h000, 10'h010};
        rq_wdata = {8'h00, 8'h5A};
        rq_raddr = {10'h000, 10'h010};
        #1;
        chk("fwd_wen_ren", {30'd0, mem_wen, mem_ren}, 32'd3);
        chk("fwd_grants", {28'd0, rq_wready, rq_rready}, 32'h5);
        @(negedge clk);
        rq_wvalid = 2'b00; rq_rvalid = 2'b00;
        #1;
        chk("fwd_rdvalid", {30'd0, rq_rdvalid}, 32'd1);
        chk("fwd_rdata", {24'd0, rq_rdata}, 32'h5A);

        // Back-to-back reads: read pointer now favours requester 1
        @(negedge clk);
        rq_rvalid = 2'b11;
        rq_raddr = {10'h200, 10'h100};
        #1;
        chk("rd_rr0_rready", {30'd0, rq_rready}, 32'd2);
        chk("rd_rr0_raddr", {22'd0, mem_raddr}, 32'h200);
        @(negedge clk);
        #1;
        chk("rd_rr1_rready", {30'd0, rq_rready}, 32'd1);
        chk("rd_rr1_raddr", {22'd0, mem_raddr}, 32'h100);
        chk("rd_rr0_rdvalid", {30'd0, rq_rdvalid}, 32'd2);
        chk("rd_rr0_rdata", {24'd0, rq_rdata}, 32'h22);
        @(negedge clk);
        rq_rvalid = 2'b00;
        #1;
        chk("rd_rr1_rdvalid", {30'd0, rq_rdvalid}, 32'd1);
        chk("rd_rr1_rdata", {24'd0, rq_rdata}, 32'h11);

        // Read granted, reset asserted the next cycle: no read-data strobe
        @(negedge clk);
        rq_rvalid = 2'b01;
        rq_raddr = {10'h000, 10'h100};
        #1;
        chk("abort_rready", {30'd0, rq_rready}, 32'd1);
        @(negedge clk);
        rq_rvalid = 2'b00;
        reset = 1'b1;
        #1;
        chk("abort_rdvalid0", {30'd0, rq_rdvalid}, 32'd0);
        chk("abort_ren", {31'd0, mem_ren}, 32'd0);
        @(negedge clk);
        #1;
        chk("abort_rdvalid1", {30'd0, rq_rdvalid}, 32'd0);
        chk("abort_init_done", {31'd0, init_done}, 32'd0);

        // Reset at clear cycle 500 restarts the full clear sequence
        @(negedge clk);
        reset = 1'b0;
        clear_run(500);
        reset = 1'b1;
        #1;
        chk("midclr_wen", {31'd0, mem_wen}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rq_wvalid = 2'b11;
        clear_run(1024);
        rq_wvalid = 2'b00;
        #1;
        chk("reclr_init_done", {31'd0, init_done}, 32'd1);
        chk("reclr_wen", {31'd0, mem_wen}, 32'd0);
        chk("reclr_mem0", {24'd0, mem[0]}, 32'd0);
        chk("reclr_mem3ff", {24'd0, mem[1023]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_1024x8_dp_sched.md
MEM_1024X8_DP_SCHED -- requirements
Module: mem_1024x8_dp_sched

Interface
REQ-001 Parameter: ADDR_W, 10, memory address width.
REQ-002 Parameter: DATA_W, 8, memory data width.
REQ-003 Parameter: CLEAR_ON_RESET, 1, when 1 zero-fill all 2^ADDR_W words after reset.
REQ-004 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-005 Ports (name direction width meaning): clk in 1 clock; reset in 1 sync active-high reset.
REQ-006 rq_wvalid in 2 per-requester write request; rq_wready out 2 write grant; rq_waddr in 2*ADDR_W; rq_wdata in 2*DATA_W.
REQ-007 rq_rvalid in 2 per-requester read request; rq_rready out 2 read grant; rq_raddr in 2*ADDR_W.
REQ-008 rq_rdvalid out 2 read-data strobe per requester; rq_rdata out DATA_W shared read data.
REQ-009 init_done out 1 high once memory is usable.
REQ-010 mem_waddr out ADDR_W, mem_data_in out DATA_W, mem_wen out 1, mem_raddr out ADDR_W, mem_ren out 1, mem_clk out 1 (= clk), mem_data_out in DATA_W: drive the 1024x8 dual-port memory.

Function
REQ-011 FSM states CLEAR, RUN; reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-012 CLEAR: mem_wen=1, mem_waddr=clr_cnt, mem_data_in=0, mem_ren=0, all rq_wready/rq_rready=0; clr_cnt increments each cycle from 0.
REQ-013 CLEAR->RUN on the cycle clr_cnt=2^ADDR_W-1 is written; init_done goes high the following cycle and stays high until reset.
REQ-014 RUN: write port and read port arbitrated independently, round-robin between requesters 0 and 1.
REQ-015 Per port: single requester valid -> it is granted; both valid -> requester named by that port's priority pointer granted; pointer toggles to the other requester after each grant; pointer unchanged when no grant.
REQ-016 Grants (rq_wready/rq_rready) SHALL be combinational from valids, pointer and state; a transfer completes on valid&&ready in that cycle.
REQ-017 Write grant drives mem_wen=1, mem_waddr/mem_data_in from granted requester in the same cycle; no grant -> mem_wen=0.
REQ-018 Read grant drives mem_ren=1, mem_raddr from granted requester; rq_rdvalid[granted] pulses exactly one cycle later with rq_rdata=mem_data_out; latency 1, one read per cycle sustained.
REQ-019 Same-cycle granted write and read to equal address: the read's rq_rdata SHALL return the written data (write-first forwarding via registered bypass flag and data).
REQ-020 Unselected rq_rdvalid bits SHALL be 0; rq_rdata is don't-care when no rq_rdvalid bit is set.
REQ-021 Unused mem_waddr/mem_raddr/mem_data_in SHALL be driven to 0 when the corresponding enable is low.

Reset
REQ-022 On reset: state per REQ-011, clr_cnt=0, both priority pointers=requester 0, read-pending pipeline cleared, init_done=0, rq_rdvalid=0, mem_wen=0, mem_ren=0.
REQ-023 Reset asserted mid-CLEAR or mid-RUN SHALL abandon any in-flight read (no rq_rdvalid) and restart the clear sequence.

Structure
REQ-024 ADDR_W/DATA_W defaults, FSM state encoding and requester-index constants SHALL live in shared package mem_sched_pkg.
REQ-025 One sub-module, rr_arb2 (2-way round-robin arbiter with pointer register), SHALL be instantiated twice (write port, read port).

Verification
REQ-026 Reset with CLEAR_ON_RESET=1 -> mem_wen high 1024 consecutive cycles, addresses 0..1023, data 0; init_done rises cycle 1025; grants 0 throughout.
REQ-027 Both requesters hold rq_wvalid for 4 cycles in RUN -> grants alternate 0,1,0,1; four memory writes seen in that order.
REQ-028 Requester 1 reads addr 0x3FF after requester 0 wrote 0xA5 there -> rq_rdvalid[1] one cycle after grant, rq_rdata=0xA5, rq_rdvalid[0]=0.
REQ-029 Same-cycle write 0x5A and read, both addr 0x010 -> read returns 0x5A.
REQ-030 Reset pulsed at clear cycle 500 -> clr_cnt restarts at 0, full 1024-cycle clear repeated, init_done low until completion.
REQ-031 Read granted, reset asserted next cycle -> no rq_rdvalid pulse produced.
